smac_drain: RTL and testbench
=============================

# smac_drain

Column result drain for the SubMAC array. It sits below the last `smac` of a column and consumes the 64-bit `res_mac_n` partial-sum word once the column has finished accumulating. It decodes the word according to the active precision and buffers it in a small FIFO. It then streams one 32-bit result per word to the writeback/DMA side over a valid/ready interface, marking tile boundaries with `m_tlast`.

## Interface
- `DEPTH`, 8: FIFO entries. Must be a power of 2, at least 4.
- `ROWS`, 16: result words per tile. `m_tlast` is asserted on every ROWS-th beat.
- `clk` in 1: single clock. All logic is on the rising edge.
- `aresetn` in 1: reset, asynchronous and active-low.
- `sclr` in 1: synchronous flush, active-high.
- `select_precision` in 4: one-hot integer mode. [0] int8, [1] int16, [2] int32, [3] int64-split (two int32 lanes).
- `enable_fp_unit` in 2: 2'b01 fp32, 2'b11 bf16, 2'b00 integer. 2'b10 is illegal.
- `res_mac_n` in 64: column result word.
- `res_valid` in 1: `res_mac_n` is valid this cycle.
- `in_ready` out 1: drain can accept a word.
- `stall` out 1: almost-full. Drives the column `ce` low.
- `m_tdata` out 32: decoded result.
- `m_tvalid` out 1.
- `m_tready` in 1.
- `m_tlast` out 1: last beat of a tile.
- `overflow` out 1: sticky. A word arrived with `in_ready` low.
- `err_mode` out 1: sticky. A word arrived with an illegal mode.
- `level` out clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Accept: a word is accepted when `res_valid` and `in_ready` are both high. `in_ready` is high when `level < DEPTH`.
- Drop: if `res_valid` is high and `in_ready` is low, the word is discarded, `overflow` sets, and the tile counter does not advance.
- Mode latch: the mode is captured from `select_precision` and `enable_fp_unit` on the first accepted word of a tile (tile counter = 0). It is held for the rest of the tile. Mode changes mid-tile are ignored.
- Legal modes:
  - `enable_fp_unit` = 00 with `select_precision` exactly one-hot.
  - `enable_fp_unit` = 01 or 11, with `select_precision` ignored.
- Illegal mode: a word arriving with an illegal mode at tile start is dropped and `err_mode` sets. The tile counter stays at 0.
- Decode, giving a 32-bit beat:
  - int8: `res_mac_n[7:0]` sign-extended.
  - int16: `res_mac_n[15:0]` sign-extended.
  - int32: `res_mac_n[31:0]`.
  - int64-split: two beats, `res_mac_n[31:0]` then `res_mac_n[63:32]`. The word uses 2 FIFO entries, so `in_ready` requires `level <= DEPTH-2`.
  - fp32: `res_mac_n[31:0]` raw.
  - bf16: `{res_mac_n[31:16],16'h0}`.
- Tile counter: 0..ROWS-1, incremented per accepted word. The entry written when the counter = ROWS-1 carries last=1 (in int64-split, only the second beat of that word). The counter then wraps to 0.
- Output: `m_tvalid` is high when the FIFO is non-empty. A beat pops when `m_tvalid` and `m_tready` are both high.
- Simultaneous push and pop: allowed at any level, including `level = DEPTH` (pop only, since `in_ready` is low). Occupancy is unchanged on push+pop.
- `stall` = `level >= DEPTH-2`.
- `sclr`: empties the FIFO, zeroes the tile counter, clears `overflow` and `err_mode`, and drops the latched mode. `sclr` has priority over a same-cycle push or pop.

## Timing
- Reset values (asynchronous, `aresetn` low):
  - 0: `m_tvalid`, `m_tdata`, `m_tlast`, `overflow`, `err_mode`, `level`, `stall`, tile counter.
  - `in_ready` = 1.
- Latency: a word accepted in cycle t into an empty FIFO gives `m_tvalid`=1 at t+1.
  - int64-split: the second beat is available at t+2 or later, after the first beat pops.
- `m_tdata` and `m_tlast` are registered and stable while `m_tvalid` is high and `m_tready` is low.
- `in_ready`, `stall` and `level` reflect registered occupancy. They are not combinationally dependent on `m_tready`.
- Reset mid-tile: all state is lost and the partial tile is discarded. The next accepted word is row 0.
- Sticky flags set in the cycle after the offending word. They clear only on `sclr` or reset.

## Structure
- `smac_pkg`: mode encoding constants (MODE_INT8, MODE_INT16, MODE_INT32, MODE_INT64S, MODE_FP32, MODE_BF16, MODE_ILLEGAL).
- `smac_pkg`: the mode-from-controls decode function and the lane-decode function.
- Sub-module `drain_fifo`: synchronous FIFO, 33-bit entries (data plus last), parameter DEPTH, with `level` output, registered output, and push+pop while full allowed.
- Top level: mode latch, tile counter, int64-split beat sequencer, sticky flags.

## Test plan
- int8 mode, ROWS=4, `res_mac_n`=64'h..._80, 01, 7F, FF with `m_tready`=1 → beats FFFFFF80, 00000001, 0000007F, FFFFFFFF. `m_tlast` only on the 4th beat. Each beat appears 1 cycle after its word.
- bf16 mode, word 64'h0000_0000_3F80_1234 → `m_tdata`=3F800000.
- int64-split, word 64'h11112222_33334444 → beats 33334444 then 11112222. With ROWS=1, `m_tlast` is on the second beat only.
- `m_tready`=0, DEPTH=8, 10 int32 words back-to-back:
  - `stall` rises at `level`=6.
  - `in_ready` falls at 8.
  - words 9 and 10 are dropped and `overflow`=1.
  - after `m_tready`=1, exactly words 1-8 drain in order.
- Mode change mid-tile: fp32 on row 0, `select_precision`=0001 and `enable_fp_unit`=00 on row 1 → row 1 is still decoded as fp32. Illegal 10 at row 0 → dropped, `err_mode`=1.
- `aresetn` pulse low with 3 entries queued, and separately `sclr` with a simultaneous push → `level`=0, `m_tvalid`=0, flags cleared, next tile starts at row 0.

Source files
------------

// File: rtl/smac_pkg.sv
// Shared types and decode helpers for the SubMAC column drain.
package smac_pkg;

  // Active precision of a tile, derived from the precision/FP controls.
  typedef enum logic [2:0] {
    MODE_INT8    = 3'd0,
    MODE_INT16   = 3'd1,
    MODE_INT32   = 3'd2,
    MODE_INT64S  = 3'd3,
    MODE_FP32    = 3'd4,
    MODE_BF16    = 3'd5,
    MODE_ILLEGAL = 3'd7
  } mode_e;

  // One FIFO entry: a decoded 32-bit beat plus its tile-boundary marker.
  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  // Map the raw controls onto a mode; anything not exactly legal is MODE_ILLEGAL.
  function automatic mode_e mode_from_ctrl(input logic [3:0] sel, input logic [1:0] fp);
    mode_e m;
    m = MODE_ILLEGAL;
    case (fp)
      2'b01: m = MODE_FP32;
      2'b11: m = MODE_BF16;
      2'b00: begin
        case (sel)
          4'b0001: m = MODE_INT8;
          4'b0010: m = MODE_INT16;
          4'b0100: m = MODE_INT32;
          4'b1000: m = MODE_INT64S;
          default: m = MODE_ILLEGAL;
        endcase
      end
      default: m = MODE_ILLEGAL;
    endcase
    return m;
  endfunction

  // Decode the low lane of a result word into a 32-bit beat. The upper lane
  // of an int64-split word is passed through raw by the caller.
  function automatic logic [31:0] lane_decode(input mode_e mode, input logic [31:0] lo);
    logic [31:0] d;
    case (mode)
      MODE_INT8:   d = {{24{lo[7]}}, lo[7:0]};
      MODE_INT16:  d = {{16{lo[15]}}, lo[15:0]};
      MODE_INT32,
      MODE_INT64S,
      MODE_FP32:   d = lo;
      MODE_BF16:   d = {lo[31:16], 16'h0000};
      default:     d = 32'h0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/smac_drain_fifo.sv
// Synchronous FIFO of decoded beats with a registered head and occupancy count.
// Push and pop may coincide at any level, including full.
module drain_fifo
  import smac_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     sclr,
  input  logic                     push,
  input  beat_t                    din,
  input  logic                     pop,
  output beat_t                    head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL    = LW'(DEPTH);
  localparam logic [LW-1:0] TWO     = LW'(2);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  beat_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && (level != '0);
  assign do_push = push && ((level != FULL) || do_pop);

  // Storage write.
  // NOTE: the array is deliberately not reset; level and head define what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !sclr) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the registered head beat.
  // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: ;
      endcase
      // Head always mirrors mem[rd_ptr]; refill it from the next slot or the bypass.
      if (do_pop) begin
        if (level >= TWO)  head <= mem[rd_ptr + PTR_ONE];
        else if (do_push)  head <= din;
      end else if (do_push && (level == '0)) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/smac_drain.sv
// Column result drain: latches the tile mode, decodes result words into
// 32-bit beats, splits int64 words into two beats, and streams them out.
module smac_drain
  import smac_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ROWS  = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     sclr,
  input  logic [3:0]               select_precision,
  input  logic [1:0]               enable_fp_unit,
  input  logic [63:0]              res_mac_n,
  input  logic                     res_valid,
  output logic                     in_ready,
  output logic                     stall,
  output logic [31:0]              m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic                     overflow,
  output logic                     err_mode,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [LW-1:0] FULL     = LW'(DEPTH);
  localparam logic [LW-1:0] ROOM2    = LW'(DEPTH - 2);
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);
  localparam logic [CW-1:0] ROW_ONE  = CW'(1);

  mode_e          mode_q;
  mode_e          eff_mode;
  logic [CW-1:0]  row_q;
  logic           pend_q;
  beat_t          pend_beat;
  beat_t          push_beat;
  beat_t          head;
  logic           tile_start;
  logic           need_two;
  logic           illegal;
  logic           accept;
  logic           is_last;
  logic           push;
  logic           pop;

  // At row 0 the live controls decide the mode; afterwards the latched one does.
  assign tile_start = (row_q == '0);
  assign eff_mode   = tile_start ? mode_from_ctrl(select_precision, enable_fp_unit) : mode_q;
  assign need_two   = (eff_mode == MODE_INT64S);
  assign illegal    = (eff_mode == MODE_ILLEGAL);
  assign is_last    = (row_q == LAST_ROW);

  // While the upper int64 lane waits for its slot the single write port is
  // busy, so intake pauses for that one cycle.
  assign in_ready = !pend_q && (need_two ? (level <= ROOM2) : (level != FULL));
  assign stall    = (level >= ROOM2);
  assign accept   = res_valid && in_ready && !illegal;
  assign push     = accept || pend_q;
  assign pop      = m_tvalid && m_tready;

  assign m_tvalid = (level != '0);
  assign m_tdata  = head.data;
  assign m_tlast  = head.last;

  // Select the FIFO write beat: pending upper lane first, else the decoded word.
  always_comb begin
    // NOTE: assign a default first so no path through this block infers a latch.
    push_beat = pend_beat;
    if (!pend_q) begin
      push_beat.last = is_last && !need_two;
      push_beat.data = lane_decode(eff_mode, res_mac_n[31:0]);
    end
  end

  // Tile counter, mode latch, int64 upper-lane holding register and sticky flags.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      row_q     <= '0;
      mode_q    <= MODE_ILLEGAL;
      pend_q    <= 1'b0;
      pend_beat <= '0;
      overflow  <= 1'b0;
      err_mode  <= 1'b0;
    end else if (sclr) begin
      row_q     <= '0;
      mode_q    <= MODE_ILLEGAL;
      pend_q    <= 1'b0;
      pend_beat <= '0;
      overflow  <= 1'b0;
      err_mode  <= 1'b0;
    end else begin
      pend_q <= accept && need_two;
      if (accept) begin
        row_q     <= is_last ? '0 : row_q + ROW_ONE;
        pend_beat <= {is_last, res_mac_n[63:32]};
        if (tile_start) mode_q <= eff_mode;
      end
      if (res_valid && !in_ready) overflow <= 1'b1;
      if (res_valid && illegal)   err_mode <= 1'b1;
    end
  end

  drain_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .sclr    (sclr),
    .push    (push),
    .din     (push_beat),
    .pop     (pop),
    .head    (head),
    .level   (level)
  );

endmodule

// File: tb/tb_smac_drain.sv
// Scoreboard bench for smac_drain (DEPTH=8, ROWS=4): stimulus pushes the
// hand-computed beats into a queue, a negedge monitor pops and compares.
module tb_smac_drain;

  localparam logic [3:0] SEL_I8  = 4'b0001;
  localparam logic [3:0] SEL_I32 = 4'b0100;
  localparam logic [3:0] SEL_I64 = 4'b1000;
  localparam logic [1:0] FP_INT  = 2'b00;
  localparam logic [1:0] FP_32   = 2'b01;
  localparam logic [1:0] FP_BAD  = 2'b10;
  localparam logic [1:0] FP_BF16 = 2'b11;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        sclr;
  logic [3:0]  select_precision;
  logic [1:0]  enable_fp_unit;
  logic [63:0] res_mac_n;
  logic        res_valid;
  logic        in_ready;
  logic        stall;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        overflow;
  logic        err_mode;
  logic [3:0]  level;

  logic [32:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  smac_drain #(.DEPTH(8), .ROWS(4)) dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .sclr             (sclr),
    .select_precision (select_precision),
    .enable_fp_unit   (enable_fp_unit),
    .res_mac_n        (res_mac_n),
    .res_valid        (res_valid),
    .in_ready         (in_ready),
    .stall            (stall),
    .m_tdata          (m_tdata),
    .m_tvalid         (m_tvalid),
    .m_tready         (m_tready),
    .m_tlast          (m_tlast),
    .overflow         (overflow),
    .err_mode         (err_mode),
    .level            (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic send(input logic [63:0] w, input logic [3:0] sel, input logic [1:0] fp);
    res_mac_n        = w;
    select_precision = sel;
    enable_fp_unit   = fp;
    res_valid        = 1'b1;
    tick();
    res_valid        = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 100) begin
      tick();
      n++;
    end
    check("drain_complete", 64'(exp_q.size()), 64'd0);
    check("drain_idle", 64'(m_tvalid), 64'd0);
  endtask

  // Monitor: every beat that is actually transferred must match the queue head.
  always @(negedge clk) begin
    if (aresetn && !sclr && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("beat_expected", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("beat_data", 64'(m_tdata), 64'(e[31:0]));
        check("beat_last", 64'(m_tlast), 64'(e[32]));
      end
    end
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn          = 1'b0;
    sclr             = 1'b0;
    select_precision = 4'b0000;
    enable_fp_unit   = FP_INT;
    res_mac_n        = '0;
    res_valid        = 1'b0;
    m_tready         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid",   64'(m_tvalid), 64'd0);
    check("rst_tdata",    64'(m_tdata),  64'd0);
    check("rst_tlast",    64'(m_tlast),  64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_err_mode", 64'(err_mode), 64'd0);
    check("rst_level",    64'(level),    64'd0);
    check("rst_stall",    64'(stall),    64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    aresetn = 1'b1;
    tick();

    // Tile A: int8 sign extension, one-cycle latency, last on row 3.
    m_tready = 1'b1;
    expect_beat(32'hFFFF_FF80, 1'b0);
    send(64'hDEAD_BEEF_1234_5680, SEL_I8, FP_INT);
    check("int8_latency0", 64'(m_tvalid), 64'd1);
    expect_beat(32'h0000_0001, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FF01, SEL_I8, FP_INT);
    check("int8_latency1", 64'(m_tvalid), 64'd1);
    expect_beat(32'h0000_007F, 1'b0);
    send(64'h0000_0000_0000_007F, SEL_I8, FP_INT);
    check("int8_latency2", 64'(m_tvalid), 64'd1);
    expect_beat(32'hFFFF_FFFF, 1'b1);
    send(64'h0000_0000_0000_00FF, SEL_I8, FP_INT);
    check("int8_latency3", 64'(m_tvalid), 64'd1);
    wait_drain();

    // Tile B: bf16, with int8 and illegal controls mid-tile being ignored.
    expect_beat(32'h3F80_0000, 1'b0);
    send(64'h0000_0000_3F80_1234, 4'b0000, FP_BF16);
    expect_beat(32'hC000_0000, 1'b0);
    send(64'h0000_0000_C000_00FF, SEL_I8, FP_INT);
    expect_beat(32'h4049_0000, 1'b0);
    send(64'h0000_1234_4049_0FDB, 4'b0000, FP_BAD);
    expect_beat(32'hBF80_0000, 1'b1);
    send(64'h0000_0000_BF80_5678, SEL_I32, FP_INT);
    wait_drain();
    check("midtile_no_err", 64'(err_mode), 64'd0);

    // Tile C: fp32 raw, row 1 presented with int8 controls stays fp32.
    expect_beat(32'h4049_0FDB, 1'b0);
    send(64'hFFFF_FFFF_4049_0FDB, 4'b0000, FP_32);
    expect_beat(32'h0000_0080, 1'b0);
    send(64'h0000_0000_0000_0080, SEL_I8, FP_INT);
    expect_beat(32'h1234_5678, 1'b0);
    send(64'h0000_0000_1234_5678, 4'b0000, FP_32);
    expect_beat(32'h9ABC_DEF0, 1'b1);
    send(64'h0000_0000_9ABC_DEF0, 4'b0000, FP_32);
    wait_drain();

    // Illegal modes at row 0 are dropped and set err_mode.
    send(64'h0000_0000_0000_0011, 4'b0000, FP_BAD);
    check("illegal_err",   64'(err_mode), 64'd1);
    check("illegal_level", 64'(level),    64'd0);
    send(64'h0000_0000_0000_0022, 4'b0011, FP_INT);
    check("illegal_tvalid", 64'(m_tvalid), 64'd0);
    check("illegal_no_ovf", 64'(overflow), 64'd0);

    // Tile D: int64-split, low lane then high lane, last on row 3 high lane.
    expect_beat(32'h3333_4444, 1'b0);
    expect_beat(32'h1111_2222, 1'b0);
    send(64'h1111_2222_3333_4444, SEL_I64, FP_INT);
    check("int64_latency", 64'(m_tvalid), 64'd1);
    tick();
    expect_beat(32'hBBBB_BBBB, 1'b0);
    expect_beat(32'hAAAA_AAAA, 1'b0);
    send(64'hAAAA_AAAA_BBBB_BBBB, SEL_I64, FP_INT);
    tick();
    expect_beat(32'h0000_0002, 1'b0);
    expect_beat(32'h0000_0001, 1'b0);
    send(64'h0000_0001_0000_0002, SEL_I64, FP_INT);
    tick();
    expect_beat(32'hDEAD_BEEF, 1'b0);
    expect_beat(32'hCAFE_F00D, 1'b1);
    send(64'hCAFE_F00D_DEAD_BEEF, SEL_I64, FP_INT);
    tick();
    wait_drain();
    check("err_sticky", 64'(err_mode), 64'd1);

    // Tile E: back-pressure with 10 int32 words; 9 and 10 overflow.
    m_tready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      int lvl;
      if (i <= 8) expect_beat(32'(32'h1000 + i), (i == 4) || (i == 8));
      send({32'hFFFF_0000, 32'(32'h1000 + i)}, SEL_I32, FP_INT);
      lvl = (i < 8) ? i : 8;
      check("bp_level",    64'(level),    64'(lvl));
      check("bp_stall",    64'(stall),    64'(lvl >= 6));
      check("bp_in_ready", 64'(in_ready), 64'(lvl < 8));
      check("bp_overflow", 64'(overflow), 64'(i >= 9));
    end
    m_tready = 1'b1;
    wait_drain();

    // Asynchronous reset with 3 entries queued discards the partial tile.
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) send(64'(32'h2000 + i), SEL_I32, FP_INT);
    check("prereset_level", 64'(level), 64'd3);
    aresetn = 1'b0;
    #1;
    check("arst_level",    64'(level),    64'd0);
    check("arst_tvalid",   64'(m_tvalid), 64'd0);
    check("arst_overflow", 64'(overflow), 64'd0);
    check("arst_err_mode", 64'(err_mode), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    #2;
    aresetn  = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_beat(32'(32'h3000 + i), i == 3);
      send(64'(32'h3000 + i), SEL_I32, FP_INT);
    end
    wait_drain();

    // Synchronous flush beats a same-cycle push and pop.
    m_tready = 1'b0;
    for (int i = 0; i < 9; i++) send(64'(32'h4000 + i), SEL_I32, FP_INT);
    check("presclr_level",    64'(level),    64'd8);
    check("presclr_overflow", 64'(overflow), 64'd1);
    send(64'h0000_0000_0000_0033, 4'b0000, FP_BAD);
    check("presclr_err", 64'(err_mode), 64'd1);
    res_mac_n        = 64'h0000_0000_0000_5555;
    select_precision = SEL_I32;
    enable_fp_unit   = FP_INT;
    res_valid        = 1'b1;
    sclr             = 1'b1;
    m_tready         = 1'b1;
    tick();
    res_valid = 1'b0;
    sclr      = 1'b0;
    check("sclr_level",    64'(level),    64'd0);
    check("sclr_tvalid",   64'(m_tvalid), 64'd0);
    check("sclr_overflow", 64'(overflow), 64'd0);
    check("sclr_err_mode", 64'(err_mode), 64'd0);
    check("sclr_in_ready", 64'(in_ready), 64'd1);
    check("sclr_stall",    64'(stall),    64'd0);
    for (int i = 0; i < 4; i++) begin
      expect_beat(32'h0000_FF80 + 32'(i), i == 3);
      send(64'h0000_0000_0000_FF80 + 64'(i), SEL_I32, FP_INT);
    end
    wait_drain();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
